// File: rtl/vertex_accum_buffer.sv
// Sums PARTS partial vertex results per node id and queues completed sums in a DEPTH-entry FIFO.
// Define VERTEX_ACCUM_SAT_EN to saturate accumulation instead of wrapping.
module vertex_accum_buffer #(
    parameter int FV_SIZE   = 16,
    parameter int NODE_ID_W = 7,
    parameter int PARTS     = 4,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vin_valid,
    output logic                       vin_ready,
    input  logic [FV_SIZE-1:0]         vin_data,
    input  logic [NODE_ID_W-1:0]       vin_node_id,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FV_SIZE-1:0]         out_data,
    output logic [NODE_ID_W-1:0]       out_node_id,
    output logic                       seq_err,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int CNT_W = $clog2(PARTS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int FC_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PARTS - 1);
    localparam logic [FC_W-1:0]  FULL     = FC_W'(DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t                 state_r, state_s;
    logic [FV_SIZE-1:0]     acc_r, acc_s, sum_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [NODE_ID_W-1:0]   cur_id_r, cur_id_s;
    logic                   push_s, seq_err_s, seq_err_r, accept_s, pop_s;
    logic [FV_SIZE-1:0]     mem_data_r [DEPTH];
    logic [NODE_ID_W-1:0]   mem_id_r   [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
    logic [FC_W-1:0]        count_r;

    function automatic logic [FV_SIZE-1:0] add_fn(input logic [FV_SIZE-1:0] a,
                                                  input logic [FV_SIZE-1:0] b);
        logic [FV_SIZE:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef VERTEX_ACCUM_SAT_EN
        if (s[FV_SIZE]) begin
            return {FV_SIZE{1'b1}};
        end else begin
            return s[FV_SIZE-1:0];
        end
`else
        return s[FV_SIZE-1:0];
`endif
    endfunction

    // Ready depends only on registered occupancy, never on out_ready.
    assign vin_ready   = (count_r != FULL);
    assign out_valid   = (count_r != {FC_W{1'b0}});
    assign accept_s    = vin_valid & vin_ready;
    assign pop_s       = out_valid & out_ready;
    assign fifo_count  = count_r;
    assign out_data    = mem_data_r[rd_ptr_r];
    assign out_node_id = mem_id_r[rd_ptr_r];
    assign seq_err     = seq_err_r;

    // Next-state and accumulator update for each accepted beat.
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        cnt_s     = cnt_r;
        cur_id_s  = cur_id_r;
        push_s    = 1'b0;
        seq_err_s = 1'b0;
        sum_s     = add_fn(acc_r, vin_data);
        if (accept_s) begin
            case (state_r)
                IDLE: begin
                    acc_s    = vin_data;
                    cur_id_s = vin_node_id;
                    cnt_s    = CNT_W'(1);
                    state_s  = ACCUM;
                end
                ACCUM: begin
                    if (vin_node_id != cur_id_r) begin
                        // Interrupted node: drop its partial sum and restart on the new id.
                        seq_err_s = 1'b1;
                        acc_s     = vin_data;
                        cur_id_s  = vin_node_id;
                        cnt_s     = CNT_W'(1);
                        state_s   = ACCUM;
                    end else if (cnt_r == CNT_LAST) begin
                        push_s  = 1'b1;
                        acc_s   = sum_s;
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = IDLE;
                    end else begin
                        acc_s = sum_s;
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Accumulator state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            acc_r     <= {FV_SIZE{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            cur_id_r  <= {NODE_ID_W{1'b0}};
            seq_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            acc_r     <= acc_s;
            cnt_r     <= cnt_s;
            cur_id_r  <= cur_id_s;
            seq_err_r <= seq_err_s;
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_r[i] <= {FV_SIZE{1'b0}};
                mem_id_r[i]   <= {NODE_ID_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {FC_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= sum_s;
                mem_id_r[wr_ptr_r]   <= cur_id_r;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + FC_W'(1);
                2'b01:   count_r <= count_r - FC_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
